// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, access-size
// strobes, default memory timeout, and the request legality check used when
// a request is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } lsu_state_t;

  // Right-aligned strobe patterns coming from the decoder
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam int TIMEOUT_DEFAULT = 15;

  // A request is legal when the size is one of the three encodings and the
  // address is naturally aligned for that size.
  function automatic logic req_legal(input logic [3:0] be, input logic [1:0] off);
    logic ok;
    case (be)
      BE_BYTE: ok = 1'b1;
      BE_HALF: ok = ~off[0];
      BE_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data alignment and sign/zero extension of a memory read word.
// Latency: purely combinational. Backpressure: none, no handshake.
// Ports: rdata (read word), offset (addr[1:0]), byte_en (size), sign_ext -> data.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [3:0]  byte_en,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = shifted;
    case (byte_en)
      BE_BYTE: data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      BE_HALF: data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one execute-stage request, drives a single
//   word-aligned memory access, returns aligned/extended load data.
// Latency: accept N, mem_req N+1.., ready at N+1 gives rd_valid at N+2.
// Backpressure: stall held while a request is pending, in flight, or faulting;
//   memory stretches ACCESS via mem_ready_i up to TIMEOUT_CYC cycles.
// Ports: execute request (req_valid_i, mem_wr_en_i, byte_en_i, signed_i,
//   addr_i, wr_data_i); memory (mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o,
//   mem_wdata_o, mem_ready_i, mem_rdata_i); pipeline (stall_o, rd_data_o,
//   rd_valid_o, err_o).
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic        mem_wr_en_i,
  input  logic [3:0]  byte_en_i,
  input  logic        signed_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        sign_q;
  logic        we_q;
  logic [31:0] rd_data_q;

  logic        accept;
  logic        capture;
  logic [31:0] ext_data;

  load_extend u_load_extend (
    .rdata    (mem_rdata_i),
    .offset   (addr_q[1:0]),
    .byte_en  (be_q),
    .sign_ext (sign_q),
    .data     (ext_data)
  );

  // Next-state and per-state outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    capture     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wstrb_o = 4'h0;
    mem_wdata_o = 32'h0;
    stall_o     = 1'b0;
    rd_valid_o  = 1'b0;
    err_o       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Gated by rst_n so the stall also drops while reset is held with a
        // request still presented by the execute stage.
        stall_o = req_valid_i & rst_n;
        if (req_valid_i) begin
          if (req_legal(byte_en_i, addr_i[1:0])) begin
            accept  = 1'b1;
            state_d = ACCESS;
          end else begin
            state_d = ERR;
          end
        end
      end

      ACCESS: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_wstrb_o = we_q ? (be_q << addr_q[1:0]) : 4'h0;
        mem_wdata_o = wdata_q << {addr_q[1:0], 3'b000};
        if (mem_ready_i) begin
          capture = ~we_q;
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          // This was the last permitted ACCESS cycle; give up on the memory.
          cnt_d   = '0;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        rd_valid_o = ~we_q;
        state_d    = IDLE;
      end

      ERR: begin
        stall_o = 1'b1;
        err_o   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are frozen at accept so memory sees stable values for the
  // whole ACCESS phase regardless of what the execute stage does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= addr_i;
      wdata_q <= wr_data_i;
      be_q    <= byte_en_i;
      sign_q  <= signed_i;
      we_q    <= mem_wr_en_i;
    end
  end

  // Load result register: only a completing load updates it, so stores and
  // faults leave the previous load value visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= 32'h0;
    end else if (capture) begin
      rd_data_q <= ext_data;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        mem_wr_en_i;
  logic [3:0]  byte_en_i;
  logic        signed_i;
  logic [31:0] addr_i;
  logic [31:0] wr_data_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  lsu_ctrl #(.TIMEOUT_CYC(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .mem_wr_en_i (mem_wr_en_i),
    .byte_en_i   (byte_en_i),
    .signed_i    (signed_i),
    .addr_i      (addr_i),
    .wr_data_i   (wr_data_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wstrb_o (mem_wstrb_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_o     (stall_o),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive point just after the active edge; sample point on the falling edge.
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic req(input logic we, input logic [3:0] be, input logic sgn,
                     input logic [31:0] a, input logic [31:0] wd);
    req_valid_i = 1'b1;
    mem_wr_en_i = we;
    byte_en_i   = be;
    signed_i    = sgn;
    addr_i      = a;
    wr_data_i   = wd;
  endtask

  // Load with ready in the first ACCESS cycle; checks the returned data.
  task automatic do_load(input string tag, input logic [3:0] be, input logic sgn,
                         input logic [31:0] a, input logic [31:0] rdata,
                         input logic [31:0] exp);
    go();
    req(1'b0, be, sgn, a, 32'h0);
    mid();
    go();
    req_valid_i = 1'b0;
    mem_ready_i = 1'b1;
    mem_rdata_i = rdata;
    mid();
    chk({tag, "_addr"}, mem_addr_o, {a[31:2], 2'b00});
    chk({tag, "_wstrb"}, {28'h0, mem_wstrb_o}, 32'h0);
    go();
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
    mid();
    chk({tag, "_valid"}, {31'h0, rd_valid_o}, 32'h1);
    chk({tag, "_data"}, rd_data_o, exp);
  endtask

  initial begin
    rst_n       = 1'b0;
    req(1'b0, 4'b1111, 1'b0, 32'h100, 32'hFFFF_FFFF);
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;

    // Reset: outputs quiet even with a request presented
    #12;
    chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_rd_valid", {31'h0, rd_valid_o}, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_rd_data", rd_data_o, 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);

    go();
    rst_n       = 1'b1;
    req_valid_i = 1'b0;
    mid();
    chk("idle_stall", {31'h0, stall_o}, 32'h0);

    // LW 0x100, ready one cycle after the request
    go();
    req(1'b0, 4'b1111, 1'b0, 32'h100, 32'h0);
    mid();
    chk("lw_n_stall", {31'h0, stall_o}, 32'h1);
    chk("lw_n_req", {31'h0, mem_req_o}, 32'h0);
    go();
    req_valid_i = 1'b0;
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    mid();
    chk("lw_n1_req", {31'h0, mem_req_o}, 32'h1);
    chk("lw_n1_addr", mem_addr_o, 32'h100);
    chk("lw_n1_we", {31'h0, mem_we_o}, 32'h0);
    chk("lw_n1_stall", {31'h0, stall_o}, 32'h1);
    chk("lw_n1_valid", {31'h0, rd_valid_o}, 32'h0);
    go();
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
    mid();
    chk("lw_n2_valid", {31'h0, rd_valid_o}, 32'h1);
    chk("lw_n2_data", rd_data_o, 32'hDEAD_BEEF);
    chk("lw_n2_stall", {31'h0, stall_o}, 32'h0);
    chk("lw_n2_req", {31'h0, mem_req_o}, 32'h0);
    go();
    mid();
    chk("lw_n3_valid", {31'h0, rd_valid_o}, 32'h0);
    chk("lw_n3_hold", rd_data_o, 32'hDEAD_BEEF);

    // Byte/half/word loads at various offsets
    do_load("lb", 4'b0001, 1'b1, 32'h103, 32'h8012_3456, 32'hFFFF_FF80);
    do_load("lbu", 4'b0001, 1'b0, 32'h103, 32'h8012_3456, 32'h0000_0080);
    do_load("lb1", 4'b0001, 1'b1, 32'h101, 32'h0000_7F00, 32'h0000_007F);
    do_load("lhu", 4'b0011, 1'b0, 32'h202, 32'h8001_7777, 32'h0000_8001);

    // LH signed with ready delayed to the second ACCESS cycle
    go();
    req(1'b0, 4'b0011, 1'b1, 32'h206, 32'h0);
    mid();
    go();
    req_valid_i = 1'b0;
    mem_rdata_i = 32'h8001_7777;
    mid();
    chk("lhd_c1_req", {31'h0, mem_req_o}, 32'h1);
    chk("lhd_c1_addr", mem_addr_o, 32'h204);
    go();
    mem_ready_i = 1'b1;
    mid();
    chk("lhd_c2_req", {31'h0, mem_req_o}, 32'h1);
    chk("lhd_c2_valid", {31'h0, rd_valid_o}, 32'h0);
    go();
    mem_ready_i = 1'b0;
    mid();
    chk("lhd_valid", {31'h0, rd_valid_o}, 32'h1);
    chk("lhd_data", rd_data_o, 32'hFFFF_8001);

    // SH 0x102 data 0x1234
    go();
    req(1'b1, 4'b0011, 1'b0, 32'h102, 32'h0000_1234);
    mid();
    go();
    req_valid_i = 1'b0;
    mem_ready_i = 1'b1;
    mid();
    chk("sh_wstrb", {28'h0, mem_wstrb_o}, 32'hC);
    chk("sh_wdata", mem_wdata_o, 32'h1234_0000);
    chk("sh_we", {31'h0, mem_we_o}, 32'h1);
    chk("sh_addr", mem_addr_o, 32'h100);
    go();
    mem_ready_i = 1'b0;
    mid();
    chk("sh_valid", {31'h0, rd_valid_o}, 32'h0);
    chk("sh_stall", {31'h0, stall_o}, 32'h0);
    chk("sh_rd_hold", rd_data_o, 32'hFFFF_8001);

    // LH 0x101 misaligned
    go();
    req(1'b0, 4'b0011, 1'b0, 32'h101, 32'h0);
    mid();
    chk("mis_n_stall", {31'h0, stall_o}, 32'h1);
    chk("mis_n_req", {31'h0, mem_req_o}, 32'h0);
    go();
    req_valid_i = 1'b0;
    mid();
    chk("mis_n1_err", {31'h0, err_o}, 32'h1);
    chk("mis_n1_req", {31'h0, mem_req_o}, 32'h0);
    chk("mis_n1_stall", {31'h0, stall_o}, 32'h1);
    chk("mis_n1_valid", {31'h0, rd_valid_o}, 32'h0);
    go();
    mid();
    chk("mis_n2_err", {31'h0, err_o}, 32'h0);
    chk("mis_n2_stall", {31'h0, stall_o}, 32'h0);

    // Illegal size encoding
    go();
    req(1'b1, 4'b0101, 1'b0, 32'h100, 32'h0);
    mid();
    go();
    req_valid_i = 1'b0;
    mid();
    chk("ill_err", {31'h0, err_o}, 32'h1);
    chk("ill_req", {31'h0, mem_req_o}, 32'h0);

    // LW timeout: 15 ACCESS cycles then an error pulse
    go();
    req(1'b0, 4'b1111, 1'b0, 32'h300, 32'h0);
    mid();
    for (int i = 0; i < 15; i++) begin
      go();
      req_valid_i = 1'b0;
      mid();
      chk($sformatf("to_req_%0d", i), {31'h0, mem_req_o}, 32'h1);
    end
    go();
    mid();
    chk("to_err", {31'h0, err_o}, 32'h1);
    chk("to_req_drop", {31'h0, mem_req_o}, 32'h0);
    chk("to_stall", {31'h0, stall_o}, 32'h1);
    chk("to_valid", {31'h0, rd_valid_o}, 32'h0);
    go();
    mid();
    chk("to_release", {31'h0, stall_o}, 32'h0);
    chk("to_err_end", {31'h0, err_o}, 32'h0);

    // Reset during ACCESS
    go();
    req(1'b0, 4'b1111, 1'b0, 32'h400, 32'h0);
    mid();
    go();
    req_valid_i = 1'b0;
    mid();
    chk("ra_req_pre", {31'h0, mem_req_o}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ra_req", {31'h0, mem_req_o}, 32'h0);
    chk("ra_stall", {31'h0, stall_o}, 32'h0);
    chk("ra_rd_data", rd_data_o, 32'h0);
    go();
    rst_n       = 1'b1;
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    mid();
    chk("ra_post_valid", {31'h0, rd_valid_o}, 32'h0);
    chk("ra_post_req", {31'h0, mem_req_o}, 32'h0);
    go();
    mid();
    chk("ra_post2_valid", {31'h0, rd_valid_o}, 32'h0);
    chk("ra_ready_ignored", rd_data_o, 32'h0);
    go();
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;

    // Recovery after reset
    do_load("rec", 4'b1111, 1'b0, 32'h400, 32'h1122_3344, 32'h1122_3344);

    go();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 15, max cycles in ACCESS waiting for mem_ready_i.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: req_valid_i  in  1  load/store request from execute stage.
REQ-005 SHALL have ports: mem_wr_en_i  in  1  1=store, 0=load.
REQ-006 SHALL have ports: byte_en_i  in  4  access size from decoder: 0001 byte, 0011 half, 1111 word, others illegal.
REQ-007 SHALL have ports: signed_i  in  1  load result sign-extended when 1, zero-extended when 0.
REQ-008 SHALL have ports: addr_i  in  32  byte address from ALU.
REQ-009 SHALL have ports: wr_data_i  in  32  store data, right-aligned.
REQ-010 SHALL have ports: mem_req_o  out  1 / mem_we_o  out  1 / mem_addr_o  out  32 (bits[1:0]=0) / mem_wstrb_o  out  4 / mem_wdata_o  out  32.
REQ-011 SHALL have ports: mem_ready_i  in  1 / mem_rdata_i  in  32  memory completion and read word.
REQ-012 SHALL have ports: stall_o  out  1  freezes pipeline; rd_data_o  out  32; rd_valid_o  out  1; err_o  out  1  one-cycle fault pulse.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, DONE, ERR.
REQ-014 IDLE: on req_valid_i with legal, aligned request, SHALL register addr/data/strobe/sign/we and go to ACCESS.
REQ-015 Alignment: byte any offset; half needs addr_i[0]=0; word needs addr_i[1:0]=0; misaligned or illegal byte_en_i SHALL go to ERR with no memory request.
REQ-016 stall_o SHALL be 1 combinationally in IDLE when req_valid_i=1, in ACCESS and in ERR; 0 in DONE and idle IDLE.
REQ-017 ACCESS: mem_req_o=1, mem_addr_o={addr[31:2],2'b00}, mem_wstrb_o=byte_en<<addr[1:0] (stores), 0 for loads; mem_wdata_o=wr_data<<(8*addr[1:0]); held stable until mem_ready_i.
REQ-018 ACCESS with mem_ready_i=1 SHALL go to DONE; load data captured that cycle.
REQ-019 Load extraction: word=rdata>>(8*addr[1:0]) then masked to size, bit 7/15 replicated if signed_i else zeros; word loads pass unchanged.
REQ-020 DONE: rd_valid_o=1 for exactly one cycle (loads only; 0 for stores), then IDLE; new request not accepted in DONE.
REQ-021 Minimum latency: accept cycle N, mem_req_o cycles N+1.., ready at N+1 gives rd_valid_o at N+2.
REQ-022 Timeout counter SHALL count ACCESS cycles; reaching TIMEOUT_CYC without ready SHALL go to ERR, dropping mem_req_o.
REQ-023 ERR: err_o=1 one cycle, rd_valid_o=0, then IDLE.
REQ-024 mem_ready_i outside ACCESS SHALL be ignored.
REQ-025 rd_data_o SHALL hold last loaded value until next load completes.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, counter 0, rd_data_o=0, and all other outputs 0, including mid-ACCESS (request dropped, not replayed).
REQ-027 Deassertion SHALL be synchronised externally; first accept possible first clk edge after release.

Structure
REQ-028 State enum, size encodings (BYTE/HALF/WORD strobes) and TIMEOUT default SHALL live in shared package lsu_pkg.
REQ-029 Load alignment/extension SHALL be combinational sub-module load_extend (rdata, offset, byte_en, signed -> data).

Verification
REQ-030 LW addr 0x100, rdata 0xDEADBEEF, ready 1 cycle after req -> rd_data_o=0xDEADBEEF, rd_valid_o at N+2, stall_o N..N+1.
REQ-031 LB signed addr 0x103, rdata 0x80xxxxxx -> 0xFFFFFF80; LBU same -> 0x00000080.
REQ-032 SH addr 0x102, data 0x1234 -> mem_wstrb_o=1100, mem_wdata_o=0x12340000, mem_we_o=1, rd_valid_o=0.
REQ-033 LH addr 0x101 -> err_o pulse, mem_req_o never asserted, back to IDLE in 2 cycles.
REQ-034 LW with ready never asserted -> err_o after 15 ACCESS cycles, stall released next cycle.
REQ-035 rst_n low during ACCESS -> mem_req_o 0 immediately, state IDLE, no rd_valid_o after release.
